lif_grid_sched: RTL and testbench

LIF_GRID_SCHED -- requirements
Module: lif_grid_sched

---
 rtl/lif_grid_sched.sv | 124 ++++++++++++
 tb/tb_lif_grid_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_grid_sched.sv
// lif_grid_sched: 4x4 toroidal lattice-gas grid stepped one cell per cycle through a shared lif cell.
module lif_grid_sched #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [3:0]        wr_data,
  input  logic [3:0]        rd_addr,
  output logic [3:0]        rd_data,
  input  logic              start,
  input  logic [STEP_W-1:0] steps,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] gen_count,
  output logic [3:0]        cur_cell
);
  typedef enum logic [1:0] {IDLE, EVAL, COMMIT, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cur [16];
  logic [3:0] nxt [16];
  logic [4:0] k;
  logic [STEP_W-1:0] steps_q, gen_inc;
  logic halt_seen, stop, host_wr;
  logic [1:0] r, c, r_up, r_dn, c_lf, c_rt;
  logic [3:0] in1, in2, in3, in4, lif_out;
  assign busy = state == EVAL || state == COMMIT;
  assign done = state == DONE;
  assign cur_cell = (state == EVAL) ? (k[4] ? 4'd15 : k[3:0]) : 4'd0;
  assign host_wr = wr_en && (state == IDLE || state == DONE);
  assign gen_inc = gen_count + 1'b1;
  assign stop = gen_inc == steps_q || halt_seen || halt;
  assign r = cur_cell[3:2];
  assign c = cur_cell[1:0];
  assign r_up = r - 2'd1;
  assign r_dn = r + 2'd1;
  assign c_lf = c - 2'd1;
  assign c_rt = c + 2'd1;
  assign in1 = cur[{r_up, c}];
  assign in2 = cur[{r, c_rt}];
  assign in3 = cur[{r_dn, c}];
  assign in4 = cur[{r, c_lf}];
  lif u_lif (
    .clk  (clk),
    .rst_n(~reset),
    .in1  (in1),
    .in2  (in2),
    .in3  (in3),
    .in4  (in4),
    .out  (lif_out)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? ((steps == '0) ? DONE : EVAL) : IDLE;
      EVAL:    state_n = (k == 5'd16) ? COMMIT : EVAL;
      COMMIT:  state_n = stop ? DONE : EVAL;
      default: state_n = IDLE;
    endcase
  end
  // nxt[k-1] receives the lif result one cycle after cell k-1 was issued; k=16 drains cell 15
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      steps_q   <= '0;
      gen_count <= '0;
      halt_seen <= 1'b0;
      rd_data   <= '0;
      for (int i = 0; i < 16; i++) begin
        cur[i] <= '0;
        nxt[i] <= '0;
      end
    end else begin
      state     <= state_n;
      rd_data   <= cur[rd_addr];
      k         <= (state == EVAL) ? k + 5'd1 : 5'd0;
      halt_seen <= busy ? (halt_seen || halt) : 1'b0;
      if (state == IDLE && start) begin
        steps_q   <= steps;
        gen_count <= '0;
      end
      if (state == EVAL && k != 5'd0)
        nxt[k[3:0] - 4'd1] <= lif_out;
      if (state == COMMIT) begin
        gen_count <= gen_inc;
        for (int i = 0; i < 16; i++) cur[i] <= nxt[i];
      end
      if (host_wr)
        cur[wr_addr] <= wr_data;
    end
  end
endmodule

// lif: registered lattice-gas cell update; bit2 moves south, bit0 moves north, lateral hits scatter randomly.
module lif (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] in4,
  output logic [3:0] out
);
  logic [7:0] lfsr;
  logic [3:0] v, res;
  assign v = {1'b0, in1[2], 1'b0, in3[0]};
  always_comb begin
    res = (v == 4'b0101) ? 4'b0000 :
          (v != 4'b0000) ? v :
          (|{in2, in4}) ? (lfsr[0] ? 4'b1010 : 4'b0101) : 4'b0000;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'h01;
      out  <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      out  <= res;
    end
  end
endmodule

// File: tb/tb_lif_grid_sched.sv
// tb_lif_grid_sched: directed table, control/abort sequences and random grids against a cell-rule model.
module tb_lif_grid_sched;
  logic clk = 0, reset = 1, wr_en = 0, start = 0, halt = 0;
  logic [3:0] wr_addr = 0, wr_data = 0, rd_addr = 0;
  logic [7:0] steps = 0;
  logic [3:0] rd_data, cur_cell;
  logic busy, done;
  logic [7:0] gen_count;
  int errors = 0, checks = 0;
  logic [3:0] mg [16];
  typedef struct {
    logic [3:0]  a0, v0, a1, v1;
    logic [63:0] exp;
    logic [15:0] rnd;
  } vec_t;
  vec_t tbl [3];

  lif_grid_sched #(.STEP_W(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .steps(steps), .halt(halt),
    .busy(busy), .done(done), .gen_count(gen_count), .cur_cell(cur_cell)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_rnd(input string nm, input logic [3:0] got);
    checks++;
    if (got !== 4'b1010 && got !== 4'b0101) begin
      errors++;
      $display("FAIL %s: got %b expected 1010 or 0101", nm, got);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
  endtask

  task automatic write(input logic [3:0] a, input logic [3:0] d);
    @(negedge clk); wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge clk); wr_en = 0;
  endtask

  task automatic read(input logic [3:0] a, output logic [3:0] d);
    @(negedge clk); rd_addr = a;
    @(negedge clk); d = rd_data;
  endtask

  // n = index of the first edge (counting the start edge as 0) that samples done high
  task automatic run(input logic [7:0] s, output int n, output bit bz);
    @(negedge clk); start = 1; steps = s;
    @(negedge clk); start = 0; n = 1; bz = busy;
    while (!done && n < 3000) begin
      @(negedge clk); n++; bz |= busy;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic check_grid(input string tag, input logic [63:0] exp, input logic [15:0] rnd);
    logic [3:0] v;
    for (int i = 0; i < 16; i++) begin
      read(4'(i), v);
      if (rnd[i]) chk_rnd($sformatf("%s_cell%0d", tag, i), v);
      else chk($sformatf("%s_cell%0d", tag, i), v, exp[i*4 +: 4]);
    end
  endtask

  // One generation: south-movers arrive from the north, north-movers from the south,
  // head-on pairs annihilate, an empty cell with an occupied side neighbour scatters.
  task automatic model_grid(output logic [63:0] e, output logic [15:0] rm);
    logic [3:0] n, s, ea, w, val;
    int r, c;
    e = '0; rm = '0;
    for (int i = 0; i < 16; i++) begin
      r = i / 4; c = i % 4;
      n = mg[((r + 3) % 4) * 4 + c];
      s = mg[((r + 1) % 4) * 4 + c];
      ea = mg[r * 4 + (c + 1) % 4];
      w = mg[r * 4 + (c + 3) % 4];
      val = 4'b0000;
      if (n[2] && s[0]) val = 4'b0000;
      else if (n[2]) val = 4'b0100;
      else if (s[0]) val = 4'b0001;
      else rm[i] = (ea != 0) || (w != 0);
      e[i*4 +: 4] = val;
    end
  endtask

  initial begin
    int n;
    bit bz;
    logic [3:0] v;
    logic [63:0] e;
    logic [15:0] rm;
    logic [7:0] s;
    tbl[0] = '{a0: 4'd5, v0: 4'b0100, a1: 4'd5, v1: 4'b0100, exp: 64'h0000_0040_0000_0000, rnd: 16'h0050};
    tbl[1] = '{a0: 4'd0, v0: 4'b0001, a1: 4'd0, v1: 4'b0001, exp: 64'h0001_0000_0000_0000, rnd: 16'h000A};
    tbl[2] = '{a0: 4'd1, v0: 4'b0100, a1: 4'd9, v1: 4'b0001, exp: 64'h0000_0000_0000_0000, rnd: 16'h0505};

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_gen", gen_count, 0);
    chk("rst_cur_cell", cur_cell, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk); reset = 0;
    check_grid("rst", 64'h0, 16'h0);

    for (int t = 0; t < 3; t++) begin
      pulse_reset();
      write(tbl[t].a0, tbl[t].v0);
      write(tbl[t].a1, tbl[t].v1);
      run(8'd1, n, bz);
      chk($sformatf("vec%0d_latency", t), n, 19);
      chk($sformatf("vec%0d_busy_seen", t), bz, 1);
      chk($sformatf("vec%0d_gen", t), gen_count, 1);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", t), done, 0);
      chk($sformatf("vec%0d_busy_after", t), busy, 0);
      check_grid($sformatf("vec%0d", t), tbl[t].exp, tbl[t].rnd);
    end

    pulse_reset();
    write(4'd7, 4'd3);
    run(8'd0, n, bz);
    chk("zero_latency", n, 1);
    chk("zero_busy_seen", bz, 0);
    chk("zero_gen", gen_count, 0);
    read(4'd7, v);
    chk("zero_grid_kept", v, 3);

    pulse_reset();
    @(negedge clk); start = 1; steps = 8'd5;
    @(negedge clk); start = 0; n = 1;
    while (!done && n < 3000) begin
      if (n == 4) chk("cur_cell_k3", cur_cell, 3);
      if (n == 5) begin start = 1; steps = 8'd1; end
      if (n == 6) start = 0;
      if (n == 8) begin wr_en = 1; wr_addr = 4'd3; wr_data = 4'hF; end
      if (n == 9) wr_en = 0;
      if (n == 17) chk("cur_cell_k16", cur_cell, 15);
      if (n == 18) begin
        chk("cur_cell_commit", cur_cell, 0);
        chk("busy_commit", busy, 1);
      end
      if (n == 25) halt = 1;
      if (n == 26) halt = 0;
      @(negedge clk); n++;
    end
    chk("halt_latency", n, 37);
    chk("halt_gen", gen_count, 2);
    bz = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); bz |= busy | done;
    end
    chk("no_second_run", bz, 0);
    read(4'd3, v);
    chk("busy_write_ignored", v, 0);

    pulse_reset();
    write(4'd5, 4'b0100);
    @(negedge clk); start = 1; steps = 8'd3;
    @(negedge clk); start = 0;
    repeat (6) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    reset = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_gen", gen_count, 0);
    chk("abort_cur_cell", cur_cell, 0);
    @(negedge clk); reset = 0;
    check_grid("abort", 64'h0, 16'h0);
    run(8'd1, n, bz);
    chk("abort_rerun_latency", n, 19);
    chk("abort_rerun_gen", gen_count, 1);
    check_grid("abort_rerun", 64'h0, 16'h0);

    for (int t = 0; t < 10; t++) begin
      pulse_reset();
      for (int i = 0; i < 16; i++) mg[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      for (int i = 0; i < 16; i++) write(4'(i), mg[i]);
      run(8'd1, n, bz);
      chk($sformatf("rnd%0d_latency", t), n, 19);
      model_grid(e, rm);
      check_grid($sformatf("rnd%0d", t), e, rm);
    end

    for (int t = 0; t < 6; t++) begin
      pulse_reset();
      s = 8'($urandom_range(0, 6));
      run(s, n, bz);
      chk($sformatf("tim%0d_steps%0d_latency", t, s), n, 18 * int'(s) + 1);
      chk($sformatf("tim%0d_steps%0d_gen", t, s), gen_count, {24'd0, s});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
